// File: rtl/clkmon_pkg.sv
// Shared types and constants for the divider-output monitor.
package clkmon_pkg;

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } ch_state_e;

  // Channel i toggles every 2^i clk cycles.
  function automatic logic [CNT_W-1:0] exp_half(input int unsigned i);
    exp_half = CNT_ONE << i;
  endfunction

endpackage

// File: rtl/clkmon_channel.sv
// One monitored divider channel: edge strobes, half-period measurement and lock FSM.
module clkmon_channel
  import clkmon_pkg::*;
#(
  parameter int unsigned IDX     = 0,
  parameter int unsigned LOCK_HP = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic err_clr_i,
  input  logic div_i,
  output logic rise_o,
  output logic fall_o,
  output logic locked_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] EXP_HP    = exp_half(IDX);
  localparam logic [7:0]       LOCK_LAST = 8'(LOCK_HP - 1);

  logic             s_q, sd_q, prime_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       good_q, good_d;
  ch_state_e        state_q, state_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic             locked_q, locked_d, err_q, err_d;
  logic             edge_s, good_s, mismatch_s, err_set_s;

  // The first sample after reset seeds both stages so reset cannot fake an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_q      <= 1'b0;
      sd_q     <= 1'b0;
      prime_q  <= 1'b0;
      cnt_q    <= '0;
      good_q   <= 8'd0;
      state_q  <= IDLE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_q      <= div_i;
      sd_q     <= prime_q ? s_q : div_i;
      prime_q  <= 1'b1;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      state_q  <= state_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign edge_s     = s_q ^ sd_q;
  assign good_s     = edge_s && (cnt_q == EXP_HP);
  assign mismatch_s = (edge_s && (cnt_q != EXP_HP)) || (!edge_s && (cnt_q > EXP_HP));

  always_comb begin
    cnt_d     = cnt_q;
    good_d    = good_q;
    state_d   = state_q;
    err_set_s = 1'b0;

    if (!en_i) begin
      cnt_d = '0;
    end else if (edge_s) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    if (!en_i) begin
      state_d = IDLE;
      good_d  = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          good_d = 8'd0;
          if (edge_s) state_d = ARMED;
          else        state_d = IDLE;
        end
        ARMED: begin
          if (good_s) begin
            if (good_q == LOCK_LAST) begin
              state_d = LOCKED;
              good_d  = 8'd0;
            end else begin
              good_d = good_q + 8'd1;
            end
          end else if (mismatch_s) begin
            good_d = 8'd0;
          end else begin
            good_d = good_q;
          end
        end
        LOCKED: begin
          if (mismatch_s) begin
            state_d   = ARMED;
            good_d    = 8'd0;
            err_set_s = 1'b1;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d = IDLE;
          good_d  = 8'd0;
        end
      endcase
    end

    // A new error outranks a simultaneous clear.
    if (err_set_s)      err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;

    rise_d   = en_i & edge_s & s_q;
    fall_d   = en_i & edge_s & ~s_q;
    locked_d = (state_d == LOCKED);
  end

  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign locked_o = locked_q;
  assign err_o    = err_q;

endmodule

// File: rtl/clock_divider_monitor.sv
// Monitors the /2, /4, /8 divider outputs as clk-domain data, one channel each.
module clock_divider_monitor
  import clkmon_pkg::*;
#(
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned LOCK_HP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              err_clr,
  input  logic [NUM_CH-1:0] div_in,
  output logic [NUM_CH-1:0] rise_stb,
  output logic [NUM_CH-1:0] fall_stb,
  output logic [NUM_CH-1:0] locked,
  output logic [NUM_CH-1:0] err
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clkmon_channel #(
      .IDX     (g),
      .LOCK_HP (LOCK_HP)
    ) u_ch (
      .clk_i     (clk),
      .rst_i     (rst),
      .en_i      (en),
      .err_clr_i (err_clr),
      .div_i     (div_in[g]),
      .rise_o    (rise_stb[g]),
      .fall_o    (fall_stb[g]),
      .locked_o  (locked[g]),
      .err_o     (err[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_monitor.sv
// Directed bench for clock_divider_monitor with a behavioural /2,/4,/8 source.
module tb_clock_divider_monitor;

  logic       clk, rst, en, err_clr;
  logic [2:0] div_in;
  logic [2:0] rise_stb, fall_stb, locked, err;

  int checks = 0;
  int errors = 0;
  int k;
  logic [2:0] h1, h2, h3, dc, nd;
  logic       run_div, hold0, stuck1, ratio6, r6;
  logic [1:0] c6;

  clock_divider_monitor #(.NUM_CH(3), .LOCK_HP(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .err_clr  (err_clr),
    .div_in   (div_in),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .locked   (locked),
    .err      (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one clock; div_in changes right after edge k like a divider flop.
  task automatic adv();
    @(posedge clk);
    #1;
    k  = k + 1;
    h3 = h2;
    h2 = h1;
    h1 = div_in;
    if (run_div) begin
      dc = dc + 3'd1;
      nd = ~dc;
      if (ratio6) begin
        if (c6 == 2'd2) begin
          c6 = 2'd0;
          r6 = ~r6;
        end else begin
          c6 = c6 + 2'd1;
        end
        nd[2] = r6;
      end
      if (hold0)  nd[0] = div_in[0];
      if (stuck1) nd[1] = 1'b1;
      div_in = nd;
    end
  endtask

  // Starts a clean divider from 000 and checks lock timing, strobes and err.
  task automatic run_lock_sequence(input string name, input logic [2:0] err_exp);
    logic [2:0] exp_lk;
    dc = 3'd7;
    run_div = 1'b1;
    k = -1;
    for (int n = 0; n < 41; n++) begin
      adv();
      exp_lk = {(k >= 34), (k >= 18), (k >= 10)};
      checks++;
      if (locked !== exp_lk) begin
        errors++;
        $display("FAIL %s_locked k=%0d: got %b expected %b", name, k, locked, exp_lk);
      end
      checks++;
      if ({rise_stb, fall_stb} !== {h2 & ~h3, ~h2 & h3}) begin
        errors++;
        $display("FAIL %s_strobe k=%0d: got rise=%b fall=%b expected rise=%b fall=%b",
                 name, k, rise_stb, fall_stb, h2 & ~h3, ~h2 & h3);
      end
      checks++;
      if (err !== err_exp) begin
        errors++;
        $display("FAIL %s_err k=%0d: got %b expected %b", name, k, err, err_exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; err_clr = 1'b0; div_in = 3'b000;
    h1 = 3'b000; h2 = 3'b000; h3 = 3'b000;
    dc = 3'd7; run_div = 1'b0; hold0 = 1'b0; stuck1 = 1'b0; ratio6 = 1'b0;
    r6 = 1'b0; c6 = 2'd0; k = 0;
    #45;
    checks++;
    if ({rise_stb, fall_stb, locked, err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_values: got %h expected 000", {rise_stb, fall_stb, locked, err});
    end
    #5 rst = 1'b0;
    repeat (3) adv();
    checks++;
    if ({rise_stb, fall_stb, locked, err} !== 12'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected 000", {rise_stb, fall_stb, locked, err});
    end
  endtask

  task automatic test_clean_lock();
    en = 1'b1;
    run_lock_sequence("clean", 3'b000);
  endtask

  task automatic test_strobe_timing();
    for (int n = 0; n < 25; n++) begin
      adv();
      checks++;
      if ({rise_stb, fall_stb} !== {h2 & ~h3, ~h2 & h3}) begin
        errors++;
        $display("FAIL strobe_timing k=%0d: got rise=%b fall=%b expected rise=%b fall=%b",
                 k, rise_stb, fall_stb, h2 & ~h3, ~h2 & h3);
      end
    end
  endtask

  task automatic test_stuck_fault();
    logic found;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      adv();
      if (div_in[1] && !h1[1]) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stuck_sync: got no rise on div_in[1] expected one within 8 cycles");
    end
    stuck1 = 1'b1;
    repeat (4) adv();
    checks++;
    if (locked !== 3'b111 || err !== 3'b000) begin
      errors++;
      $display("FAIL stuck_early: got locked=%b err=%b expected 111/000", locked, err);
    end
    adv();
    checks++;
    if (locked !== 3'b101 || err !== 3'b010) begin
      errors++;
      $display("FAIL stuck_detect: got locked=%b err=%b expected 101/010", locked, err);
    end
    repeat (5) adv();
    checks++;
    if (locked !== 3'b101 || err !== 3'b010) begin
      errors++;
      $display("FAIL stuck_isolation: got locked=%b err=%b expected 101/010", locked, err);
    end
    stuck1 = 1'b0;
  endtask

  task automatic test_enable_drop();
    en = 1'b0;
    adv();
    checks++;
    if (locked !== 3'b000 || rise_stb !== 3'b000 || fall_stb !== 3'b000 || err !== 3'b010) begin
      errors++;
      $display("FAIL enable_drop: got locked=%b rise=%b fall=%b err=%b expected 000/000/000/010",
               locked, rise_stb, fall_stb, err);
    end
    run_div = 1'b0;
    div_in  = 3'b000;
    repeat (4) adv();
    en = 1'b1;
    run_lock_sequence("relock", 3'b010);
  endtask

  task automatic test_err_clr_race();
    adv();
    hold0 = 1'b1;
    adv();
    hold0 = 1'b0;
    adv();
    adv();
    checks++;
    if (err !== 3'b010) begin
      errors++;
      $display("FAIL race_pre: got err=%b expected 010", err);
    end
    err_clr = 1'b1;
    adv();
    err_clr = 1'b0;
    checks++;
    if (err !== 3'b001 || locked !== 3'b110) begin
      errors++;
      $display("FAIL race_set_wins: got err=%b locked=%b expected 001/110", err, locked);
    end
    adv();
    err_clr = 1'b1;
    adv();
    err_clr = 1'b0;
    checks++;
    if (err !== 3'b000) begin
      errors++;
      $display("FAIL err_clear: got err=%b expected 000", err);
    end
  endtask

  task automatic test_wrong_ratio();
    en = 1'b0;
    ratio6 = 1'b1;
    c6 = 2'd0;
    r6 = div_in[2];
    repeat (3) adv();
    en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      adv();
      checks++;
      if ({locked[2], err[2]} !== 2'b00) begin
        errors++;
        $display("FAIL wrong_ratio k=%0d: got locked2=%b err2=%b expected 0/0", k, locked[2], err[2]);
      end
    end
    checks++;
    if (locked !== 3'b011 || err !== 3'b000) begin
      errors++;
      $display("FAIL wrong_ratio_others: got locked=%b err=%b expected 011/000", locked, err);
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    checks++;
    if ({rise_stb, fall_stb, locked, err} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 000", {rise_stb, fall_stb, locked, err});
    end
    run_div = 1'b0;
    ratio6  = 1'b0;
    div_in  = 3'b111;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      adv();
      checks++;
      if (rise_stb !== 3'b000 || fall_stb !== 3'b000) begin
        errors++;
        $display("FAIL reset_no_strobe n=%0d: got rise=%b fall=%b expected 000/000", n, rise_stb, fall_stb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_strobe_timing();
    test_stuck_fault();
    test_enable_drop();
    test_err_clr_race();
    test_wrong_ratio();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_divider_monitor.md
Name: clock_divider_monitor

Overview:
Checker stage that sits directly downstream of the clock divider. It consumes the divider's divide-by-2^(i+1) outputs as clk-domain data, not as clocks. For each channel it produces single-cycle rise/fall enable strobes for downstream logic. It also continuously measures each channel's half-period, reports per-channel lock, and raises sticky error flags on ratio violations.

Parameters:
- NUM_CH, 3: number of divided inputs. Channel i is a divide-by-2^(i+1) signal with expected half-period 2^i clk cycles.
- CNT_W, 8: half-period counter width. Requires 2^(NUM_CH-1) < 2^CNT_W - 1.
- LOCK_HP, 8: consecutive good half-periods required to declare lock (1..255).

Ports:
- clk  in  1  system clock; the same clock that drives the divider.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  monitor enable; synchronous.
- err_clr  in  1  synchronous clear of all err bits.
- div_in  in  NUM_CH  divider outputs; bit0 = divideby2, bit1 = divideby4, bit2 = divideby8.
- rise_stb  out  NUM_CH  one-cycle pulse per detected rising edge.
- fall_stb  out  NUM_CH  one-cycle pulse per detected falling edge.
- locked  out  NUM_CH  channel verified at the expected ratio.
- err  out  NUM_CH  sticky error: a locked channel lost its ratio.

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values: all outputs 0, all channels in IDLE, counters 0, internal samples 0.
- div_in is same-domain data, so there is no synchronizer.
  - Stage 1 registers s <= div_in; stage 2 keeps s_d <= s.
  - Edge = s != s_d. Polarity comes from s.
- Strobes are registered. A div_in change sampled at clk edge n gives a strobe high for exactly the cycle following edge n+2 (2-cycle latency).
- Half-period counter cnt, one per channel:
  - Loaded with 1 on every detected edge.
  - Otherwise increments by 1 per cycle, saturating at 2^CNT_W-1.
  - A half-period is good if an edge arrives while cnt == 2^i.
- Per-channel FSM:
  - IDLE -> ARMED on the first detected edge while en=1. That edge is not measured.
  - ARMED:
    - good edge: good_cnt += 1; at good_cnt == LOCK_HP -> LOCKED and locked <= 1.
    - edge with cnt != 2^i: good_cnt <= 0, stay in ARMED.
    - cnt > 2^i with no edge (stuck or slow input): good_cnt <= 0, stay in ARMED.
  - LOCKED:
    - good edges keep LOCKED.
    - any mismatch (wrong edge timing, or cnt > 2^i): -> ARMED, locked <= 0, err[i] <= 1, good_cnt <= 0. This happens in the same cycle the mismatch is detected.
- en=0:
  - All channels -> IDLE next cycle; locked and strobes drop to 0.
  - err is held; counters are held at 0.
  - Re-enabling requires a fresh first edge, then LOCK_HP good half-periods.
- err_clr:
  - Clears all err bits on the next edge.
  - If an err set and err_clr occur in the same cycle, set wins.
- Reset mid-operation: immediate return to reset values. No strobe is emitted for an edge caused by the reset itself.
- Channels are fully independent; a fault on one never affects another.

Decomposition:
- Package clkmon_pkg holds:
  - channel state enum {IDLE, ARMED, LOCKED};
  - function exp_half(i) returning 2^i at CNT_W width;
  - localparam CNT_MAX = 2^CNT_W-1.
- One sub-module, clkmon_channel, owns the sample/edge/counter/FSM for a single channel. It is instantiated NUM_CH times in a generate loop with its index as a parameter. The top level only adds en/err_clr fan-out.

Test Plan:
- Clean lock: clk period 20 ns; rst=1 for 50 ns, then 0; en=1; drive div_in from a correct /2,/4,/8 divider.
  -> locked[0] after 1+8 half-periods +2 latency (11 cycles).
  -> locked[1] at 1+16+2 (19 cycles); locked[2] at 1+32+2 (35 cycles).
  -> err stays 000.
- Strobe timing: a rising edge on div_in[2] sampled at clk edge n.
  -> rise_stb[2] is high only in the cycle after edge n+2; fall_stb stays 0; exactly one strobe per edge over 500 ns.
- Stuck fault: after lock, hold div_in[1] high.
  -> 3 cycles after the last edge (cnt = 3 > 2) locked[1] = 0 and err[1] = 1.
  -> channels 0 and 2 stay locked.
- Wrong ratio: feed channel 2 a /6 pattern (half-period 3).
  -> locked[2] never asserts; err[2] stays 0 because the channel was never locked.
- Error clear race: pulse err_clr in the same cycle a new mismatch sets err[0].
  -> err[0] = 1. A later err_clr alone -> err = 000.
- Enable/reset mid-operation: drop en while locked.
  -> next cycle locked = 000, strobes 0, err held.
  -> on re-enable, relock takes the same time as clean lock.
  -> asserting rst asynchronously mid-period forces all outputs to 0 immediately.
